// File: rtl/seq_cla_addsub_if.sv
// Operand/result handshake bundle for the sequential CLA adder/subtractor.
// The producer/consumer side uses master; the arithmetic block uses slave.
interface seq_cla_addsub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, result, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, result, cout, overflow
    );
endinterface

// File: rtl/seq_cla_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one SLICE-bit carry-lookahead slice per clock,
// with the slice carry registered between cycles. valid/ready on both sides.
module seq_cla_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_cla_addsub_if.slave   io_bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH % SLICE != 0) begin : g_param_check
        $error("seq_cla_addsub: WIDTH must be an integer multiple of SLICE");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_overflow;

    logic [BASE_W-1:0]  w_base;
    logic [SLICE-1:0]   w_sa;
    logic [SLICE-1:0]   w_sb;
    logic [SLICE-1:0]   w_g;
    logic [SLICE-1:0]   w_p;
    logic [SLICE:0]     w_c;
    logic [SLICE-1:0]   w_sum;
    logic               w_last;

    assign w_base = BASE_W'(r_idx) * BASE_W'(SLICE);
    assign w_sa   = SLICE'(r_a >> w_base);
    assign w_sb   = SLICE'(r_b >> w_base);
    assign w_last = (r_idx == IDX_W'(NSLICE - 1));

    // Lookahead carries: each c[i+1] is expanded into its sum-of-products form.
    always_comb begin
        logic acc;
        logic prod;
        acc    = 1'b0;
        prod   = 1'b0;
        w_g    = w_sa & w_sb;
        w_p    = w_sa ^ w_sb;
        w_c    = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < int'(SLICE); i++) begin
            acc  = w_g[i];
            prod = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & w_g[j]);
                prod = prod & w_p[j];
            end
            w_c[i+1] = acc | (prod & r_carry);
        end
        w_sum = w_p ^ w_c[SLICE-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (io_bus.in_valid)  w_state_nxt = S_CALC;
            S_CALC:  if (w_last)           w_state_nxt = S_DONE;
            S_DONE:  if (io_bus.out_ready) w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.in_valid) begin
                        // Subtraction is a + ~b + ~borrow_in.
                        r_a     <= io_bus.a;
                        r_b     <= io_bus.sub ? ~io_bus.b : io_bus.b;
                        r_carry <= io_bus.sub ? ~io_bus.cin : io_bus.cin;
                        r_idx   <= '0;
                    end
                end
                S_CALC: begin
                    r_result[w_base +: SLICE] <= w_sum;
                    r_carry                   <= w_c[SLICE];
                    r_idx                     <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_cout     <= w_c[SLICE];
                        r_overflow <= w_c[SLICE] ^ w_c[SLICE-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.result    = r_result;
    assign io_bus.cout      = r_cout;
    assign io_bus.overflow  = r_overflow;
endmodule

// File: tb/tb_seq_cla_addsub.sv
// Scoreboard bench for seq_cla_addsub: directed vectors plus random ops with random out_ready.
module tb_seq_cla_addsub;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned SLICE = 4;

    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_cla_addsub_if #(.WIDTH(WIDTH)) bus ();

    seq_cla_addsub #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    exp_t sb_q[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference from plain integer arithmetic and operand/result sign rules.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input logic c);
        logic [16:0] f;
        exp_t        e;
        if (!s) begin
            f      = {1'b0, a} + {1'b0, b} + 17'(c);
            e.cout = f[16];
            e.ovf  = (a[15] == b[15]) && (f[15] != a[15]);
        end else begin
            f      = {1'b0, a} - {1'b0, b} - 17'(c);
            e.cout = ~f[16];
            e.ovf  = (a[15] != b[15]) && (f[15] != a[15]);
        end
        e.res = f[15:0];
        return e;
    endfunction

    task automatic issue_exp(input logic [15:0] a, input logic [15:0] b,
                             input logic s, input logic c, input exp_t e);
        int n = 0;
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
        bus.cin      = c;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready=%0b, expected 1", bus.in_ready);
        end else begin
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic issue_model(input logic [15:0] a, input logic [15:0] b,
                               input logic s, input logic c);
        issue_exp(a, b, s, c, model(a, b, s, c));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the following posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: result=0x%0h with empty scoreboard, expected none",
                             bus.result);
                end else begin
                    e = sb_q.pop_front();
                    check("result",   32'(bus.result),   32'(e.res));
                    check("cout",     32'(bus.cout),     32'(e.cout));
                    check("overflow", 32'(bus.overflow), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int cyc;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    32'(bus.result),    32'd0);
        check("rst_cout",      32'(bus.cout),      32'd0);
        check("rst_overflow",  32'(bus.overflow),  32'd0);
        rst_n = 1'b1;

        // Simple add with latency measurement from the accept edge.
        issue_exp(16'h0001, 16'h000C, 1'b0, 1'b1, exp_t'{16'h000E, 1'b0, 1'b0});
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.out_valid) break;
        end
        check("latency", 32'(cyc), 32'd4);
        wait_drain();

        issue_exp(16'hFFFF, 16'h0001, 1'b0, 1'b0, exp_t'{16'h0000, 1'b1, 1'b0});
        issue_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, exp_t'{16'h8000, 1'b0, 1'b1});
        issue_exp(16'h8000, 16'h0001, 1'b1, 1'b0, exp_t'{16'h7FFF, 1'b1, 1'b1});
        issue_exp(16'h0005, 16'h0007, 1'b1, 1'b0, exp_t'{16'hFFFE, 1'b0, 1'b0});
        issue_exp(16'h000A, 16'h0003, 1'b1, 1'b1, exp_t'{16'h0006, 1'b1, 1'b0});
        issue_exp(16'h0000, 16'h8000, 1'b1, 1'b0, exp_t'{16'h8000, 1'b0, 1'b1});
        wait_drain();

        // Backpressure: result held, new operands refused while DONE.
        bus.out_ready = 1'b0;
        issue_exp(16'h1111, 16'h2222, 1'b0, 1'b0, exp_t'{16'h3333, 1'b0, 1'b0});
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            bus.a        = 16'hDEAD;
            bus.b        = 16'hBEEF;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_result_stable", 32'(bus.result),    32'h3333);
            check("bp_in_ready_low",  32'(bus.in_ready),  32'd0);
            check("bp_valid_held",    32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_after", 32'(bus.in_ready),  32'd1);
        check("bp_valid_after",    32'(bus.out_valid), 32'd0);
        check("bp_scoreboard",     32'(sb_q.size()),   32'd0);

        // Reset during the second CALC cycle abandons the operation.
        @(negedge clk);
        bus.a        = 16'hAAAA;
        bus.b        = 16'h5555;
        bus.sub      = 1'b0;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("mid_accepted", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("mid_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_result",    32'(bus.result),    32'd0);
        issue_exp(16'h1234, 16'h4321, 1'b0, 1'b0, exp_t'{16'h5555, 1'b0, 1'b0});
        wait_drain();

        rand_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            issue_model(16'($urandom), 16'($urandom),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
